fetch_sequencer: RTL and testbench

- Sequences the byte-addressed, little-endian, combinational-read instruction memory for the pipelined RV64 core.
- Owns the PC and drives the memory address.
- Captures each 32-bit word with its PC into a small FIFO and presents it to the IF/ID stage over a valid/ready handshake.
- Handles branch redirects (flush plus PC reload) and end-of-program halt.

---
 rtl/fetch_pkg.sv | 10 +
 rtl/inst_fifo.sv | 43 ++++
 rtl/fetch_sequencer.sv | 73 +++++++
 tb/tb_fetch_sequencer.sv | 125 ++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch sequencer.
package fetch_pkg;
  localparam int INST_BYTES = 4;
  localparam logic [31:0] NOP_INST = 32'h00000013;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HALT} fetch_state_t;
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/inst_fifo.sv
// inst_fifo: small instruction FIFO with flush; a full FIFO still accepts a push alongside a pop.
module inst_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           din,
  output fetch_entry_t           dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign do_pop = pop & ~empty & ~flush;
  assign do_push = push & (~full | do_pop) & ~flush;
  assign dout = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, fetches from combinational imem into a FIFO and feeds decode.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'd0,
  parameter logic [63:0] END_PC = 64'd180,
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [63:0] id_pc,
  output logic        halted,
  output logic        misalign_err
);
  fetch_state_t state, state_next;
  logic [63:0] pc, pc_next, target;
  logic push, flush, pop, space, full, empty, halted_next, misalign_next;
  logic [$clog2(DEPTH):0] count;
  fetch_entry_t head;
  inst_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .flush(flush),
    .din('{pc: pc, inst: imem_rdata}), .dout(head), .count(count), .full(full), .empty(empty)
  );
  assign imem_addr = pc;
  assign id_valid = count != '0;
  assign id_inst = head.inst;
  assign id_pc = head.pc;
  assign pop = id_valid & id_ready;
  assign space = ~full | pop;
  assign target = {redirect_pc[63:2], 2'b00};
  always_comb begin
    state_next = state;
    pc_next = pc;
    push = 1'b0;
    flush = 1'b0;
    misalign_next = misalign_err | (redirect_valid & |redirect_pc[1:0]);
    halted_next = state == HALT & ~redirect_valid;
    if (state == IDLE) begin
      pc_next = redirect_valid ? target : pc;
      state_next = start ? FETCH : IDLE;
    end else if (redirect_valid) begin
      flush = 1'b1;
      pc_next = target;
      state_next = FETCH;
    end else if (state == FETCH) begin
      if (pc >= END_PC) state_next = DRAIN;
      else if (space) begin
        push = 1'b1;
        pc_next = pc + 64'(INST_BYTES);
      end
    end else if (state == DRAIN && empty) state_next = HALT;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      pc <= RESET_PC;
      halted <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      state <= state_next;
      pc <= pc_next;
      halted <= halted_next;
      misalign_err <= misalign_next;
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: table-driven vectors plus directed drain/halt/reset sequences.
module tb_fetch_sequencer;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, redirect_valid = 1'b0, id_ready = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic [63:0] imem_addr, id_pc;
  logic [31:0] imem_rdata, id_inst;
  logic id_valid, halted, misalign_err;
  int tests = 0, fails = 0;
  typedef struct {
    logic st, rv;
    logic [63:0] rpc;
    logic rdy, e_valid;
    logic [63:0] e_pc, e_addr;
    logic e_mis;
  } vec_t;
  vec_t v[16];
  fetch_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst), .id_pc(id_pc),
    .halted(halted), .misalign_err(misalign_err)
  );
  function automatic logic [31:0] mem(input logic [63:0] a);
    return a == 64'd0 ? 32'h00000013 : a == 64'd88 ? 32'h00028313 : {16'hC0DE, a[15:0]};
  endfunction
  assign imem_rdata = mem(imem_addr);
  always #5 clk = ~clk;
  function automatic vec_t mk(input logic st, rv, input logic [63:0] rpc, input logic rdy, ev,
                              input logic [63:0] ep, ea, input logic em);
    vec_t r;
    r.st = st; r.rv = rv; r.rpc = rpc; r.rdy = rdy;
    r.e_valid = ev; r.e_pc = ep; r.e_addr = ea; r.e_mis = em;
    return r;
  endfunction
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  task automatic run_to_halt(input logic [63:0] first, input int n);
    int k = 0, cyc = 0;
    bit seen_empty = 0;
    while (!halted && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (id_valid) begin
        chk("stream_pc", id_pc, first + 64'(4 * k));
        chk("stream_inst", 64'(id_inst), 64'(mem(first + 64'(4 * k))));
        k++;
      end else if (k > 0 && !seen_empty) begin
        seen_empty = 1;
        chk("halted_low_on_empty", 64'(halted), 64'd0);
      end
    end
    chk("halted_reached", 64'(halted), 64'd1);
    chk("handshakes", 64'(k), 64'(n));
    chk("halt_valid", 64'(id_valid), 64'd0);
  endtask
  initial begin
    v[0]  = mk(1, 0, 0,   0, 0, 0,   0,   0);
    v[1]  = mk(0, 0, 0,   0, 1, 0,   4,   0);
    v[2]  = mk(0, 0, 0,   0, 1, 0,   8,   0);
    v[3]  = mk(0, 0, 0,   0, 1, 0,   8,   0);
    v[4]  = mk(0, 0, 0,   1, 1, 4,   12,  0);
    v[5]  = mk(0, 0, 0,   0, 1, 4,   12,  0);
    v[6]  = mk(0, 0, 0,   1, 1, 8,   16,  0);
    v[7]  = mk(0, 0, 0,   1, 1, 12,  20,  0);
    v[8]  = mk(0, 0, 0,   1, 1, 16,  24,  0);
    v[9]  = mk(0, 0, 0,   1, 1, 20,  28,  0);
    v[10] = mk(0, 1, 88,  1, 0, 0,   88,  0);
    v[11] = mk(0, 0, 0,   1, 1, 88,  92,  0);
    v[12] = mk(0, 0, 0,   1, 1, 92,  96,  0);
    v[13] = mk(0, 1, 90,  1, 0, 0,   88,  1);
    v[14] = mk(0, 1, 100, 1, 0, 0,   100, 1);
    v[15] = mk(0, 0, 0,   1, 1, 100, 104, 1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_valid", 64'(id_valid), 64'd0);
    chk("rst_pc", id_pc, 64'd0);
    chk("rst_inst", 64'(id_inst), 64'd0);
    chk("rst_addr", imem_addr, 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_mis", 64'(misalign_err), 64'd0);
    for (int i = 0; i < 16; i++) begin
      start = v[i].st; redirect_valid = v[i].rv; redirect_pc = v[i].rpc; id_ready = v[i].rdy;
      @(negedge clk);
      chk($sformatf("v%0d_valid", i), 64'(id_valid), 64'(v[i].e_valid));
      chk($sformatf("v%0d_pc", i), id_pc, v[i].e_valid ? v[i].e_pc : 64'd0);
      chk($sformatf("v%0d_inst", i), 64'(id_inst), v[i].e_valid ? 64'(mem(v[i].e_pc)) : 64'd0);
      chk($sformatf("v%0d_addr", i), imem_addr, v[i].e_addr);
      chk($sformatf("v%0d_mis", i), 64'(misalign_err), 64'(v[i].e_mis));
    end
    start = 0; redirect_valid = 0; id_ready = 0;
    repeat (2) @(negedge clk);
    chk("full_valid", 64'(id_valid), 64'd1);
    chk("full_addr", imem_addr, 64'd108);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_valid", 64'(id_valid), 64'd0);
    chk("async_rst_addr", imem_addr, 64'd0);
    chk("async_rst_mis", 64'(misalign_err), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    id_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle_valid", 64'(id_valid), 64'd0);
      chk("idle_addr", imem_addr, 64'd0);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_to_halt(64'd0, 45);
    redirect_valid = 1'b1; redirect_pc = 64'd156;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("redir_halted_drop", 64'(halted), 64'd0);
    chk("redir_halt_addr", imem_addr, 64'd156);
    run_to_halt(64'd156, 6);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
